alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the 4-bit combinational ALU used in the tt_um_adammaj top level.
- Accepts WIDTH-bit unsigned operands through a valid/ready handshake.
- Executes ADD/SUB in one cycle and MUL/DIV iteratively over WIDTH cycles.
- Presents a double-width result plus flags, held until the consumer accepts it.
- Drops into the top-level wrapper in place of the old ALU: ui_in carries the operands, uio_in carries the op and handshake bits.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16.
CNT_W, $clog2(WIDTH+1), localparam; width of the iteration counter.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand/op bundle is valid.
in_ready  output  1  block can accept a bundle; high only in IDLE.
rs  input  WIDTH  operand A (unsigned).
rt  input  WIDTH  operand B (unsigned); divisor for DIV.
alu_arithmetic_mux  input  2  op select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
alu_out  output  WIDTH  low result: sum, difference, product low half, or quotient.
alu_out_hi  output  WIDTH  high result: product high half or remainder; 0 for ADD/SUB.
alu_flags  output  4  [0] zero, [1] carry/borrow, [2] div_by_zero, [3] illegal_op.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=1; out_valid=0; alu_out, alu_out_hi and alu_flags = 0. An in-flight operation is discarded. Reset has priority over every other event.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid=1, latch rs, rt and the op at the clock edge.
  - ADD/SUB go to DONE.
  - MUL/DIV go to BUSY with counter=WIDTH.
- BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle, counter decrements. At counter==1 the final step completes and the FSM goes to DONE. rs/rt/op/in_valid are ignored while BUSY.
- DONE: out_valid=1 and all outputs held stable. When out_ready=1 the FSM returns to IDLE and out_valid drops on the next cycle. in_ready=0 while DONE; there is no overlap of successive operations.
- Latency from the accept edge to out_valid: ADD/SUB 1 cycle; MUL/DIV WIDTH+1 cycles.
- Result registers change only on the edge that enters DONE.
- Arithmetic rules (all unsigned, modulo 2^WIDTH):
  - ADD: {carry, alu_out} = rs+rt; alu_out_hi=0.
  - SUB: alu_out = rs-rt; carry = borrow (rs<rt); alu_out_hi=0.
  - MUL: {alu_out_hi, alu_out} = rs*rt; carry=0.
  - DIV: alu_out = rs/rt; alu_out_hi = rs%rt.
  - DIV with rt==0: runs the full WIDTH cycles; alu_out = all ones, alu_out_hi = rs, div_by_zero=1. This is the natural output of restoring division.
- zero flag = (alu_out==0) && (alu_out_hi==0), for every op.
- in_valid and out_ready arriving in the same cycle while in DONE: only out_ready takes effect. The bundle is accepted no earlier than the following IDLE cycle.

Optional Feature:
ALU_DIV_EN.
- Defined: DIV is implemented as specified above; illegal_op is never set.
- Undefined: the divider datapath is compiled out. DIV is accepted like ADD (DONE after 1 cycle) with alu_out=0, alu_out_hi=0, zero=1, carry=0, div_by_zero=0, illegal_op=1.

Decomposition:
- Package alu_pkg:
  - op enum: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_DIV=2'b11.
  - state enum: IDLE, BUSY, DONE.
  - flag bit-index constants: FLAG_ZERO=0, FLAG_CARRY=1, FLAG_DZ=2, FLAG_ILL=3.
- One sub-module, alu_muldiv: the iterative shift-add / restoring-division datapath and its counter, with start/step/finish signals.
- alu_seq keeps the FSM, the handshake, the ADD/SUB logic and the output registers.

Test Plan (WIDTH=4, ALU_DIV_EN defined unless noted):
- ADD rs=9, rt=8, out_ready=1 -> out_valid one cycle after accept; alu_out=0x1, alu_out_hi=0, flags carry=1, zero=0.
- SUB rs=3, rt=5 -> alu_out=0xE, carry=1. SUB rs=5, rt=5 -> alu_out=0, zero=1, carry=0.
- MUL rs=15, rt=15 -> out_valid exactly 5 cycles after accept; alu_out_hi=0xE, alu_out=0x1. Changing rs/rt during BUSY does not alter the result.
- DIV rs=13, rt=4 -> alu_out=3, alu_out_hi=1. DIV rs=7, rt=0 -> alu_out=0xF, alu_out_hi=7, div_by_zero=1. With ALU_DIV_EN undefined, DIV 13/4 -> 1-cycle latency, outputs 0, zero=1, illegal_op=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no new bundle accepted. On the out_ready=1 edge the FSM goes to IDLE; in_ready=1 on the next cycle.
- Reset asserted on the 2nd BUSY cycle of MUL -> next cycle: IDLE, out_valid=0, in_ready=1, all outputs 0. A following ADD 2+2 returns 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq / alu_muldiv).
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_DZ    = 2;
    localparam int FLAG_ILL   = 3;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle over WIDTH cycles.
// The divider half exists only when ALU_DIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
`ifdef ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // acc_lo holds the multiplier (MUL) or the dividend turning into the quotient (DIV)
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic             div_mode;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
    assign res_hi    = div_mode ? div_rem : mul_hi;
    assign res_lo    = div_mode ? {acc_lo[WIDTH-2:0], div_ge} : mul_lo;
`else
    assign res_hi = mul_hi;
    assign res_lo = mul_lo;
`endif

    assign finish = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(WIDTH);
        end else if (step && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_hi <= '0;
`ifdef ALU_DIV_EN
            div_mode <= is_div;
            acc_lo   <= is_div ? a : b;
            opnd     <= is_div ? b : a;
`else
            acc_lo <= b;
            opnd   <= a;
`endif
        end else if (step && cnt != '0) begin
            acc_hi <= res_hi;
            acc_lo <= res_lo;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/SUB, iterative MUL/DIV, held double-width result.
// Define ALU_DIV_EN to build the divider; otherwise DIV reports illegal_op.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [1:0]       alu_arithmetic_mux,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic [3:0]       alu_flags
);

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                                              input logic carry, input logic dz, input logic ill);
        logic [3:0] f;
        f              = '0;
        f[FLAG_ZERO]   = (lo == '0) && (hi == '0);
        f[FLAG_CARRY]  = carry;
        f[FLAG_DZ]     = dz;
        f[FLAG_ILL]    = ill;
        return f;
    endfunction

    alu_state_e       state;
    alu_op_e          op_in;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic             quick_done;
    logic [WIDTH-1:0] quick_lo;
    logic [3:0]       quick_flags;
    logic             md_start;
    logic             md_finish;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_dz;

    assign op_in    = alu_op_e'(alu_arithmetic_mux);
    assign add_sum  = {1'b0, rs} + {1'b0, rt};
    assign sub_diff = {1'b0, rs} - {1'b0, rt};

    // Ops that finish on the accept edge; MUL (and DIV when built) go to the iterative unit
    always_comb begin
        quick_done  = 1'b1;
        quick_lo    = '0;
        quick_flags = '0;
        case (op_in)
            ALU_ADD: begin
                quick_lo    = add_sum[WIDTH-1:0];
                quick_flags = make_flags(add_sum[WIDTH-1:0], '0, add_sum[WIDTH], 1'b0, 1'b0);
            end
            ALU_SUB: begin
                quick_lo    = sub_diff[WIDTH-1:0];
                quick_flags = make_flags(sub_diff[WIDTH-1:0], '0, sub_diff[WIDTH], 1'b0, 1'b0);
            end
            ALU_MUL: quick_done = 1'b0;
`ifdef ALU_DIV_EN
            ALU_DIV: quick_done = 1'b0;
`else
            ALU_DIV: quick_flags = make_flags('0, '0, 1'b0, 1'b0, 1'b1);
`endif
            default: quick_done = 1'b1;
        endcase
    end

    assign md_start = (state == IDLE) && in_valid && !quick_done;

`ifdef ALU_DIV_EN
    logic dz_latched;

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            dz_latched <= (op_in == ALU_DIV) && (rt == '0);
        end
    end

    assign md_dz = dz_latched;
`else
    assign md_dz = 1'b0;
`endif

    alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .step   (state == BUSY),
`ifdef ALU_DIV_EN
        .is_div (op_in == ALU_DIV),
`endif
        .a      (rs),
        .b      (rt),
        .finish (md_finish),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            alu_out    <= '0;
            alu_out_hi <= '0;
            alu_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (quick_done) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            alu_out    <= quick_lo;
                            alu_out_hi <= '0;
                            alu_flags  <= quick_flags;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (md_finish) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        alu_out    <= md_lo;
                        alu_out_hi <= md_hi;
                        alu_flags  <= make_flags(md_lo, md_hi, 1'b0, md_dz, 1'b0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=4): directed vectors, expected results queued at issue time.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [1:0]       alu_arithmetic_mux;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_out_hi;
    logic [3:0]       alu_flags;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .rs                 (rs),
        .rt                 (rt),
        .alu_arithmetic_mux (alu_arithmetic_mux),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .alu_out            (alu_out),
        .alu_out_hi         (alu_out_hi),
        .alu_flags          (alu_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] flags;
        int         lat;
        int         acc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on the first cycle of each result, then require it to hold while stalled
    logic       prev_valid = 1'b0;
    logic [3:0] held_lo, held_hi, held_f;

    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1) begin
            chk("in_ready_low_in_done", in_ready, 0);
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_lo"}, alu_out, e.lo);
                    chk({e.name, "_hi"}, alu_out_hi, e.hi);
                    chk({e.name, "_flags"}, alu_flags, e.flags);
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                end
            end else begin
                chk("hold_lo", alu_out, held_lo);
                chk("hold_hi", alu_out_hi, held_hi);
                chk("hold_flags", alu_flags, held_f);
            end
            held_lo <= alu_out;
            held_hi <= alu_out_hi;
            held_f  <= alu_flags;
        end
        prev_valid <= (!reset && out_valid === 1'b1);
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("result_timeout", sb.size(), 0);
    endtask

    task automatic push_exp(input string name, input logic [3:0] lo, input logic [3:0] hi,
                            input logic [3:0] flags, input int lat);
        exp_t e;
        e.name = name; e.lo = lo; e.hi = hi; e.flags = flags; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] flags,
                         input int lat, input bit wiggle);
        wait_ready();
        rs = a; rt = b; alu_arithmetic_mux = op; in_valid = 1'b1;
        push_exp(name, lo, hi, flags, lat);
        @(negedge clk);
        in_valid = 1'b0;
        if (wiggle) begin
            for (int i = 0; i < WIDTH - 1; i++) begin
                rs = 4'($urandom); rt = 4'($urandom); alu_arithmetic_mux = 2'($urandom);
                in_valid = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        rs = '0; rt = '0; alu_arithmetic_mux = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_alu_out_hi", alu_out_hi, 0);
        chk("rst_flags", alu_flags, 0);
        reset = 1'b0;
        @(negedge clk);

        issue("add9_8",   2'd0, 4'd9,  4'd8, 4'h1, 4'h0, 4'b0010, 1, 1'b0);
        issue("add15_1",  2'd0, 4'd15, 4'd1, 4'h0, 4'h0, 4'b0011, 1, 1'b0);
        issue("sub3_5",   2'd1, 4'd3,  4'd5, 4'hE, 4'h0, 4'b0010, 1, 1'b0);
        issue("sub5_5",   2'd1, 4'd5,  4'd5, 4'h0, 4'h0, 4'b0001, 1, 1'b0);
        issue("mul15_15", 2'd2, 4'd15, 4'd15, 4'h1, 4'hE, 4'b0000, 5, 1'b1);
        issue("mul3_5",   2'd2, 4'd3,  4'd5, 4'hF, 4'h0, 4'b0000, 5, 1'b0);
        issue("mul0_7",   2'd2, 4'd0,  4'd7, 4'h0, 4'h0, 4'b0001, 5, 1'b0);
`ifdef ALU_DIV_EN
        issue("div13_4",  2'd3, 4'd13, 4'd4, 4'h3, 4'h1, 4'b0000, 5, 1'b1);
        issue("div7_0",   2'd3, 4'd7,  4'd0, 4'hF, 4'h7, 4'b0100, 5, 1'b0);
        issue("div3_5",   2'd3, 4'd3,  4'd5, 4'h0, 4'h3, 4'b0000, 5, 1'b0);
`else
        issue("div13_4",  2'd3, 4'd13, 4'd4, 4'h0, 4'h0, 4'b1001, 1, 1'b0);
        issue("div7_0",   2'd3, 4'd7,  4'd0, 4'h0, 4'h0, 4'b1001, 1, 1'b0);
`endif

        // Backpressure: result held while a new bundle waits with in_valid high
        wait_ready();
        out_ready = 1'b0;
        rs = 4'd6; rt = 4'd7; alu_arithmetic_mux = 2'd0; in_valid = 1'b1;
        push_exp("bp_add6_7", 4'hD, 4'h0, 4'b0000, 1);
        @(negedge clk);
        rs = 4'd1; rt = 4'd1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after_release", in_ready, 1);
        chk("bp_out_valid_after_release", out_valid, 0);
        push_exp("bp_add1_1", 4'h2, 4'h0, 4'b0000, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // Reset on the second BUSY cycle of a multiply
        wait_ready();
        rs = 4'd3; rt = 4'd3; alu_arithmetic_mux = 2'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_alu_out", alu_out, 0);
        chk("mrst_alu_out_hi", alu_out_hi, 0);
        chk("mrst_flags", alu_flags, 0);
        repeat (WIDTH + 2) begin
            @(negedge clk);
            chk("mrst_no_stale_result", out_valid, 0);
        end
        issue("add2_2", 2'd0, 4'd2, 4'd2, 4'h4, 4'h0, 4'b0000, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
